// File: rtl/ras_circular_pkg.sv
// Frontend predictor types shared by the return-address stack and its wrapper.
//   ras_t      : prediction payload (valid + return address) carried on predictor interfaces
//   ras_op_e   : per-cycle stack operation decoded from push/pop
package ras_circular_pkg;

    localparam int unsigned RAS_VLEN = 32;

    typedef struct packed {
        logic                valid;
        logic [RAS_VLEN-1:0] ra;
    } ras_t;

    typedef enum logic [1:0] {
        RAS_OP_NONE = 2'b00,
        RAS_OP_PUSH = 2'b01,
        RAS_OP_POP  = 2'b10,
        RAS_OP_SWAP = 2'b11
    } ras_op_e;

endpackage

// File: rtl/ras_circular.sv
// Return-address stack: circular buffer of DEPTH entries; push on predicted call,
// pop on predicted return, oldest entry silently overwritten when full.
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset
//   flush_i           drop all entries (count=0), contents left in place
//   push_i, pop_i     predicted call / return; both together replace the top
//   data_i            return address to push
//   valid_o, ra_o     top entry valid / top return address (read of registered state)
//   count_o           number of valid entries
module ras_circular
    import ras_circular_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned VLEN  = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [VLEN-1:0]            data_i,
    output logic                       valid_o,
    output logic [VLEN-1:0]            ra_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [VLEN-1:0]  entry_q [DEPTH];
    logic [PTR_W-1:0] tp_q, tp_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PTR_W-1:0] tp_inc, tp_dec;
    logic [PTR_W-1:0] wr_idx;
    logic             wr_en;
    ras_op_e          op;

    // Modulo-DEPTH pointer steps via compare-and-reset so non-power-of-two depths wrap correctly
    assign tp_inc = (tp_q == PTR_LAST) ? '0 : tp_q + PTR_W'(1);
    assign tp_dec = (tp_q == '0) ? PTR_LAST : tp_q - PTR_W'(1);

    assign op = ras_op_e'({pop_i, push_i});

    // Next pointer/count and entry write selection; flush dominates push/pop
    always_comb begin
        tp_d   = tp_q;
        cnt_d  = cnt_q;
        wr_en  = 1'b0;
        wr_idx = tp_q;
        if (flush_i) begin
            tp_d  = PTR_LAST;
            cnt_d = '0;
        end else begin
            unique case (op)
                RAS_OP_PUSH: begin
                    tp_d   = tp_inc;
                    wr_en  = 1'b1;
                    wr_idx = tp_inc;
                    cnt_d  = (cnt_q == CNT_FULL) ? cnt_q : cnt_q + CNT_W'(1);
                end
                RAS_OP_POP: begin
                    if (cnt_q != '0) begin
                        tp_d  = tp_dec;
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                RAS_OP_SWAP: begin
                    // Return then call: overwrite top in place; on empty stack act as a push
                    if (cnt_q != '0) begin
                        wr_en  = 1'b1;
                        wr_idx = tp_q;
                    end else begin
                        tp_d   = tp_inc;
                        wr_en  = 1'b1;
                        wr_idx = tp_inc;
                        cnt_d  = CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Pointer and count registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tp_q  <= PTR_LAST;
            cnt_q <= '0;
        end else begin
            tp_q  <= tp_d;
            cnt_q <= cnt_d;
        end
    end

    // Entry storage; cleared on reset so ra_o never carries X
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                entry_q[i] <= '0;
            end
        end else if (wr_en) begin
            entry_q[wr_idx] <= data_i;
        end
    end

    assign valid_o = (cnt_q != '0);
    assign ra_o    = entry_q[tp_q];
    assign count_o = cnt_q;

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (cnt_q <= CNT_FULL) else $error("ras_circular: count exceeds DEPTH");
            assert (tp_q <= PTR_LAST) else $error("ras_circular: top pointer out of range");
        end
    end
`endif

endmodule
